conv_result_streamer: RTL

//  Reader for the conv layer result BRAMs. On start, it sweeps read addresses 0..OUTPUT_SIZE-1 over
//  NUM_FILTERS result banks in lockstep (1-cycle read latency) and emits one packed beat per pixel
//  on a valid/ready stream, with end-of-row and end-of-frame tags. It sits between the layer BRAMs
//  (rd_addr/rd_data ports of top) and the downstream consumer (next layer, DMA or dump logic).

---
 rtl/conv_result_streamer.sv | 101 ++++++++++
 1 files changed

// File: rtl/conv_result_streamer.sv
// conv_result_streamer: sweeps the result banks in lockstep and streams one packed, tagged beat per pixel
module conv_result_streamer #(
    parameter int RESULT_WIDTH = 22,
    parameter int ADDR_WIDTH   = 18,
    parameter int OUT_W        = 222,
    parameter int OUT_H        = 222,
    parameter int OUTPUT_SIZE  = OUT_W * OUT_H,
    parameter int NUM_FILTERS  = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [ADDR_WIDTH-1:0]               rd_addr,
    input  logic [NUM_FILTERS*RESULT_WIDTH-1:0] rd_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_FILTERS*RESULT_WIDTH-1:0] out_data,
    output logic                                out_eol,
    output logic                                out_eof,
    output logic                                busy,
    output logic                                done
);
    localparam int DW = NUM_FILTERS * RESULT_WIDTH;
    localparam int EW = DW + 2;
    localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, issue_addr;
    logic [CW-1:0]         col_q, col_d;
    logic                  pend_q, pend_d, pend_eol_q, pend_eol_d, pend_eof_q, pend_eof_d;
    logic [1:0]            cnt_q, cnt_d, occ, slot;
    logic [EW-1:0]         e0_q, e0_d, e1_q, e1_d, new_e;
    logic                  issue, pop, is_eol, is_eof, last_issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            col_q      <= '0;
            pend_q     <= 1'b0;
            pend_eol_q <= 1'b0;
            pend_eof_q <= 1'b0;
            cnt_q      <= '0;
            e0_q       <= '0;
            e1_q       <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            pend_q     <= pend_d;
            pend_eol_q <= pend_eol_d;
            pend_eof_q <= pend_eof_d;
            cnt_q      <= cnt_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? (last_issue ? DRAIN : READ) : IDLE;
            READ:    state_d = last_issue ? DRAIN : READ;
            DRAIN:   state_d = (pop && cnt_q == 2'd1 && !pend_q) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = state_q != IDLE;
        done = state_q == DONE;
    end

    // The start cycle itself issues address 0, so the first beat appears two cycles after start.
    always_comb begin
        pop        = cnt_q != 2'd0 && out_ready;
        occ        = cnt_q + {1'b0, pend_q} - {1'b0, pop};
        issue      = (state_q == IDLE && start) || (state_q == READ && occ < 2'd2);
        issue_addr = state_q == IDLE ? '0 : addr_q + 1'b1;
        is_eol     = col_q == CW'(OUT_W - 1);
        is_eof     = issue_addr == ADDR_WIDTH'(OUTPUT_SIZE - 1);
        last_issue = issue && is_eof;
        rd_addr    = issue ? issue_addr : addr_q;
        addr_d     = state_q == DONE ? '0 : rd_addr;
        col_d      = !issue ? col_q : (is_eol ? '0 : col_q + 1'b1);
        pend_d     = issue;
        pend_eol_d = is_eol;
        pend_eof_d = is_eof;
        new_e      = {pend_eof_q, pend_eol_q, rd_data};
        slot       = cnt_q - {1'b0, pop};
        cnt_d      = slot + {1'b0, pend_q};
        e0_d       = (pend_q && slot == 2'd0) ? new_e : (pop ? e1_q : e0_q);
        e1_d       = (pend_q && slot == 2'd1) ? new_e : e1_q;
        out_valid  = cnt_q != 2'd0;
        out_data   = e0_q[DW-1:0];
        out_eol    = e0_q[DW];
        out_eof    = e0_q[DW+1];
    end
endmodule
